leaf_stream_demux: RTL



---
 rtl/leaf_pkt_pkg.sv | 29 ++
 rtl/leaf_stream_demux_if.sv | 13 +
 rtl/leaf_port_fifo.sv | 53 +++++
 rtl/leaf_stream_demux.sv | 79 +++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// BFT leaf packet layout and decoder shared by the leaf ingress stage.
package leaf_pkt_pkg;
  localparam int PKT_W     = 49;
  localparam int PAYLOAD_W = 32;
  localparam int VALID_BIT = 48;
  localparam int ADDR_MSB  = 47;
  localparam int ADDR_LSB  = 43;
  localparam int PORT_MSB  = 42;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
  localparam int PORT_W    = PORT_MSB - PORT_LSB + 1;

  typedef struct packed {
    logic                 vld;
    logic [ADDR_W-1:0]    addr;
    logic [PORT_W-1:0]    port;
    logic [PAYLOAD_W-1:0] data;
  } leaf_pkt_t;

  // Reserved bits [38:32] are dropped here and never reach the register.
  function automatic leaf_pkt_t decode(input logic [PKT_W-1:0] raw);
    leaf_pkt_t p;
    p.vld  = raw[VALID_BIT];
    p.addr = raw[ADDR_MSB:ADDR_LSB];
    p.port = raw[PORT_MSB:PORT_LSB];
    p.data = raw[PAYLOAD_W-1:0];
    return p;
  endfunction
endpackage

// File: rtl/leaf_stream_demux_if.sv
// Per-port operator streams: head word, non-empty flag and consume strobe.
interface leaf_stream_demux_if
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS*PAYLOAD_W-1:0] m_data;
  logic [NUM_PORTS-1:0]           m_valid;
  logic [NUM_PORTS-1:0]           m_ready;

  modport master (output m_data, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/leaf_port_fifo.sv
// Show-ahead FIFO; the head word is visible combinationally while non-empty
// and the last popped word is held while empty.
module leaf_port_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  last_q;
  logic          do_rd, do_wr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A simultaneous pop frees the slot a full FIFO is about to receive.
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/leaf_stream_demux.sv
// BFT leaf ingress: register, classify and steer payloads into per-port
// FIFOs; full-FIFO drops raise resend so the source retransmits.
module leaf_stream_demux
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MY_LEAF    = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ap_start,
  input  logic [PKT_W-1:0]   din_leaf_bft2interface,
  leaf_stream_demux_if.master m,
  output logic               resend,
  output logic               started,
  output logic [15:0]        drop_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  leaf_pkt_t                            in_q;
  logic [NUM_PORTS-1:0]                 sel, can_acc, wr_en, full, empty;
  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0]  head;
  logic [NUM_PORTS-1:0][CW-1:0]         unused_occ;
  logic                                 unused_rsvd;
  logic                                 addr_ok, port_ok, tgt_ok, accept, drop, full_drop;

  assign unused_rsvd = ^din_leaf_bft2interface[PORT_LSB-1:PAYLOAD_W];

  // Gating at capture means nothing is counted before ap_start has been seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= '0;
      started <= 1'b0;
    end else begin
      in_q     <= decode(din_leaf_bft2interface);
      in_q.vld <= din_leaf_bft2interface[VALID_BIT] & started;
      if (ap_start) started <= 1'b1;
    end
  end

  assign addr_ok   = (in_q.addr == ADDR_W'(MY_LEAF));
  assign port_ok   = ({1'b0, in_q.port} < (PORT_W+1)'(NUM_PORTS));
  assign tgt_ok    = |(sel & can_acc);
  assign accept    = in_q.vld & addr_ok & port_ok & tgt_ok;
  assign full_drop = in_q.vld & addr_ok & port_ok & ~tgt_ok;
  assign drop      = in_q.vld & ~accept;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign sel[p]     = (in_q.port == PORT_W'(p));
    assign can_acc[p] = ~full[p] | (m.m_ready[p] & ~empty[p]);
    assign wr_en[p]   = accept & sel[p];

    leaf_port_fifo #(.DEPTH(FIFO_DEPTH), .W(PAYLOAD_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en[p]),
      .wr_data (in_q.data),
      .full    (full[p]),
      .rd_en   (m.m_ready[p]),
      .rd_data (head[p]),
      .empty   (empty[p]),
      .count   (unused_occ[p])
    );
  end

  assign m.m_data  = head;
  assign m.m_valid = ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resend   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      resend <= full_drop;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule
